// File: rtl/sat_accum_stream_pkg.sv
// Shared types and helpers for the saturating frame accumulator.
// Combinational definitions only; no latency or flow control here.
package sat_pkg;

    localparam int DATA_W = 32;
    localparam logic [DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [DATA_W-1:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

    // Reports through hit whether the result was clamped.
    function automatic logic [DATA_W-1:0] sat_add(
        input  logic [DATA_W-1:0] a,
        input  logic [DATA_W-1:0] b,
        output logic              hit
    );
        logic [DATA_W:0] wide;
        wide = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        hit  = wide[DATA_W] != wide[DATA_W-1];
        if (!hit) begin
            return wide[DATA_W-1:0];
        end
        return wide[DATA_W] ? SAT_MIN : SAT_MAX;
    endfunction

endpackage

// File: rtl/sat_accum_stream_if.sv
// Sample stream in, frame result out; master is the producer/consumer side.
// Plain wires; timing and flow control belong to the modules on either end.
interface sat_accum_stream_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 9
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_sat
    );
endinterface

// File: rtl/sat_accum_stream_adder_sat.sv
// Signed saturating adder, purely combinational (0 cycles).
// No flow control; the caller qualifies the result.
module adder_sat
    import sat_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);
    logic [WIDTH:0] sum_wide;

    always_comb begin
        sum_wide = {a_i[WIDTH-1], a_i} + {b_i[WIDTH-1], b_i};
        sum_o    = sum_wide[WIDTH-1:0];
        if (sum_wide[WIDTH:WIDTH-1] == 2'b01) begin
            sum_o = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (sum_wide[WIDTH:WIDTH-1] == 2'b10) begin
            sum_o = {1'b1, {(WIDTH-1){1'b0}}};
        end
    end
endmodule

// File: rtl/sat_accum_stream.sv
// Per-frame saturating sum of a signed sample stream; result registered 1 cycle after the final beat.
// While a result is held (out_valid) input is stalled until out_ready takes it.
module sat_accum_stream
    import sat_pkg::*;
#(
    parameter int WIDTH     = DATA_W,
    parameter int MAX_COUNT = 256
) (
    input  logic               clk,
    input  logic               rst,
    sat_accum_stream_if.slave  s
);
    localparam int CNT_W = $clog2(MAX_COUNT + 1);

    acc_state_t       state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sat_q;
    logic             sat_d;
    logic [WIDTH-1:0] out_data_q;
    logic [CNT_W-1:0] out_count_q;
    logic             out_sat_q;

    logic [WIDTH:0]   sum_wide;
    logic             clamp_hit;
    logic             accept;
    logic             final_beat;

    adder_sat #(.WIDTH(WIDTH)) u_adder_sat (
        .a_i   (acc_q),
        .b_i   (s.in_data),
        .sum_o (acc_d)
    );

    always_comb begin
        sum_wide   = {acc_q[WIDTH-1], acc_q} + {s.in_data[WIDTH-1], s.in_data};
        clamp_hit  = sum_wide[WIDTH] != sum_wide[WIDTH-1];
        cnt_d      = cnt_q + CNT_W'(1);
        sat_d      = sat_q | clamp_hit;
        accept     = s.in_valid && (state_q != HOLD);
        final_beat = s.in_last || (cnt_d == CNT_W'(MAX_COUNT));
    end

    // acc/cnt are already zero in IDLE, so IDLE and ACCUM share the accept path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (final_beat) begin
                            out_data_q  <= acc_d;
                            out_count_q <= cnt_d;
                            out_sat_q   <= sat_d;
                            acc_q       <= '0;
                            cnt_q       <= '0;
                            sat_q       <= 1'b0;
                            state_q     <= HOLD;
                        end else begin
                            acc_q   <= acc_d;
                            cnt_q   <= cnt_d;
                            sat_q   <= sat_d;
                            state_q <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (s.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s.in_ready  = (state_q != HOLD);
    assign s.out_valid = (state_q == HOLD);
    assign s.out_data  = out_data_q;
    assign s.out_count = out_count_q;
    assign s.out_sat   = out_sat_q;

endmodule

// File: tb/tb_sat_accum_stream.sv
// Directed scenarios plus randomized traffic against a plain-arithmetic frame-sum model.
module tb_sat_accum_stream;

    localparam int MAXC = 4;
    localparam int CW   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    logic [37:0] got;
    logic [37:0] exp;

    // Reference model: running frame sum as a wide integer, clamped after each beat.
    longint m_sum   = 0;
    int     m_cnt   = 0;
    bit     m_sat   = 1'b0;
    bit     m_hold  = 1'b0;
    longint m_rdata = 0;
    int     m_rcnt  = 0;
    bit     m_rsat  = 1'b0;

    sat_accum_stream_if #(.WIDTH(32), .CNT_W(CW)) ifc ();

    sat_accum_stream #(.WIDTH(32), .MAX_COUNT(MAXC)) dut (
        .clk (clk),
        .rst (rst),
        .s   (ifc)
    );

    always #5 clk = ~clk;

    function automatic longint clampv(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    function automatic logic [37:0] obs();
        return {ifc.out_valid, ifc.in_ready, ifc.out_data, ifc.out_count, ifc.out_sat};
    endfunction

    task automatic tick();
        bit     acc;
        bit     take;
        longint raw;
        longint c;
        acc  = ifc.in_valid && !m_hold;
        take = m_hold && ifc.out_ready;
        @(posedge clk);
        #1;
        if (rst) begin
            m_sum = 0; m_cnt = 0; m_sat = 0; m_hold = 0;
            m_rdata = 0; m_rcnt = 0; m_rsat = 0;
        end else begin
            if (take) m_hold = 0;
            if (acc) begin
                raw = m_sum + longint'($signed(ifc.in_data));
                c   = clampv(raw);
                m_cnt++;
                m_sat = m_sat | (c != raw);
                if (ifc.in_last || m_cnt == MAXC) begin
                    m_rdata = c; m_rcnt = m_cnt; m_rsat = m_sat; m_hold = 1;
                    m_sum = 0; m_cnt = 0; m_sat = 0;
                end else begin
                    m_sum = c;
                end
            end
        end
    endtask

    task automatic beat(input logic [31:0] d, input bit last);
        ifc.in_valid = 1'b1;
        ifc.in_data  = d;
        ifc.in_last  = last;
        tick();
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.in_last = 1'b0; ifc.out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        got = obs(); exp = {1'b0, 1'b1, 32'd0, 3'd0, 1'b0};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL reset_state got=%h want=%h", got, exp); end
    endtask

    task automatic test_basic();
        ifc.out_ready = 1'b1;
        beat(32'd1, 0); beat(32'd2, 0);
        checks++;
        if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b want=0", ifc.out_valid); end
        beat(32'd3, 1);
        got = obs(); exp = {1'b1, 1'b0, 32'd6, 3'd3, 1'b0};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL basic_result got=%h want=%h", got, exp); end
        tick();
        got = obs(); exp = {1'b0, 1'b1, 32'd6, 3'd3, 1'b0};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL basic_drop got=%h want=%h", got, exp); end
    endtask

    task automatic test_saturation();
        ifc.out_ready = 1'b1;
        beat(32'h7FFF_FFF0, 0); beat(32'h0000_0100, 1);
        got = obs(); exp = {1'b1, 1'b0, 32'h7FFF_FFFF, 3'd2, 1'b1};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL sat_pos got=%h want=%h", got, exp); end
        tick();
        beat(32'h8000_0000, 0); beat(32'hFFFF_FFFF, 1);
        got = obs(); exp = {1'b1, 1'b0, 32'h8000_0000, 3'd2, 1'b1};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL sat_neg got=%h want=%h", got, exp); end
        tick();
        beat(32'h7FFF_FFFF, 0); beat(32'd1, 0); beat(32'hFFFF_FFFF, 1);
        got = obs(); exp = {1'b1, 1'b0, 32'h7FFF_FFFE, 3'd3, 1'b1};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL sat_running got=%h want=%h", got, exp); end
        tick();
        beat(32'd5, 1);
        got = obs(); exp = {1'b1, 1'b0, 32'd5, 3'd1, 1'b0};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL sat_flag_clear got=%h want=%h", got, exp); end
        tick();
    endtask

    task automatic test_max_count();
        ifc.out_ready = 1'b1;
        ifc.in_valid = 1'b1; ifc.in_data = 32'd1; ifc.in_last = 1'b0;
        repeat (4) tick();
        got = obs(); exp = {1'b1, 1'b0, 32'd4, 3'd4, 1'b0};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL maxcnt_result got=%h want=%h", got, exp); end
        repeat (3) tick();
        ifc.in_valid = 1'b0;
        tick();
        got = obs(); exp = {1'b0, 1'b1, 32'd4, 3'd4, 1'b0};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL maxcnt_idle got=%h want=%h", got, exp); end
        beat(32'd0, 1);
        got = obs(); exp = {1'b1, 1'b0, 32'd2, 3'd3, 1'b0};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL maxcnt_pending got=%h want=%h", got, exp); end
        tick();
    endtask

    task automatic test_backpressure();
        ifc.out_ready = 1'b0;
        beat(32'd5, 0); beat(32'd6, 1);
        ifc.in_valid = 1'b1; ifc.in_data = 32'd100; ifc.in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            got = obs(); exp = {1'b1, 1'b0, 32'd11, 3'd2, 1'b0};
            checks++;
            if (got !== exp) begin failures++; $display("FAIL bp_hold[%0d] got=%h want=%h", i, got, exp); end
            tick();
        end
        ifc.out_ready = 1'b1;
        tick();
        got = obs(); exp = {1'b0, 1'b1, 32'd11, 3'd2, 1'b0};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL bp_release got=%h want=%h", got, exp); end
        tick();
        ifc.in_valid = 1'b0; ifc.in_last = 1'b0;
        got = obs(); exp = {1'b1, 1'b0, 32'd100, 3'd1, 1'b0};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL bp_next got=%h want=%h", got, exp); end
        tick();
    endtask

    task automatic test_single();
        ifc.out_ready = 1'b1;
        beat(32'hFFFF_FFFB, 1);
        got = obs(); exp = {1'b1, 1'b0, 32'hFFFF_FFFB, 3'd1, 1'b0};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL single got=%h want=%h", got, exp); end
        tick();
    endtask

    task automatic test_reset_mid();
        ifc.out_ready = 1'b1;
        beat(32'd10, 0); beat(32'd20, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        got = obs(); exp = {1'b0, 1'b1, 32'd0, 3'd0, 1'b0};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL rst_mid got=%h want=%h", got, exp); end
        beat(32'd7, 1);
        got = obs(); exp = {1'b1, 1'b0, 32'd7, 3'd1, 1'b0};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL rst_mid_next got=%h want=%h", got, exp); end
        ifc.out_ready = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        got = obs(); exp = {1'b0, 1'b1, 32'd0, 3'd0, 1'b0};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL rst_hold got=%h want=%h", got, exp); end
        ifc.out_ready = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            ifc.in_valid  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: ifc.in_data = 32'($urandom_range(0, 200)) - 32'd100;
                1: ifc.in_data = 32'h7FFF_FF00 + 32'($urandom_range(0, 511));
                2: ifc.in_data = 32'h8000_0000 + 32'($urandom_range(0, 511));
                default: ifc.in_data = $urandom;
            endcase
            ifc.in_last   = ($urandom_range(0, 2) == 0);
            ifc.out_ready = ($urandom_range(0, 2) != 0);
            rst           = ($urandom_range(0, 199) == 0);
            tick();
            got = obs();
            checks++;
            if (got[37:36] !== {m_hold, !m_hold}) begin
                failures++;
                $display("FAIL rand_handshake[%0d] got=%b want=%b", i, got[37:36], {m_hold, !m_hold});
            end
            exp = {got[37:36], m_rdata[31:0], m_rcnt[CW-1:0], m_rsat};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL rand_result[%0d] got=%h want=%h", i, got, exp);
            end
        end
        rst = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b1;
        tick(); tick();
    endtask

    initial begin
        ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.in_last = 1'b0; ifc.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_saturation();
        test_max_count();
        test_backpressure();
        test_single();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
